// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/sub unit among N_REQ requesters.
// Define ADDSUB_ARB_OVF_EN to add the registered signed-overflow flag rsp_ovf.
module addsub_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned W         = 32,
  parameter int unsigned ADDER_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_add,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_result,
`ifdef ADDSUB_ARB_OVF_EN
  output logic                     rsp_ovf,
`endif
  output logic                     busy,
  output logic                     as_add,
  output logic [W-1:0]             as_num1,
  output logic [W-1:0]             as_num2,
  input  logic [W-1:0]             as_result
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(ADDER_LAT + 2);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDER_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              op_q, op_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [W-1:0]      rsp_result_q, rsp_result_d;
  logic              busy_q, busy_d;
`ifdef ADDSUB_ARB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic              any_req;
  logic              found_hi, found_lo;
  logic [ID_W-1:0]   win_hi, win_lo, winner;
  logic [N_REQ-1:0]  grant_oh;
  logic              win_add;
  logic [W-1:0]      win_a, win_b;

  // Winner: lowest valid index above ptr, else lowest valid index at or below ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid[i] && (i > int'(ptr_q)) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = ID_W'(i);
      end
      if (req_valid[i] && (i <= int'(ptr_q)) && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = ID_W'(i);
      end
    end
    winner  = found_hi ? win_hi : win_lo;
    any_req = |req_valid;
  end

  // Winner one-hot and payload mux.
  always_comb begin
    grant_oh = '0;
    win_add  = 1'b0;
    win_a    = '0;
    win_b    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (ID_W'(i) == winner) begin
        grant_oh[i] = any_req;
        win_add     = req_add[i];
        win_a       = req_a[i*int'(W) +: W];
        win_b       = req_b[i*int'(W) +: W];
      end
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
`ifdef ADDSUB_ARB_OVF_EN
    ovf_d        = ovf_q;
`endif
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = rst_n ? grant_oh : '0;
          ptr_d     = winner;
          id_d      = winner;
          op_d      = win_add;
          a_d       = win_a;
          b_d       = win_b;
          cnt_d     = '0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          rsp_result_d = as_result;
`ifdef ADDSUB_ARB_OVF_EN
          ovf_d = op_q ? ((a_q[W-1] == b_q[W-1]) && (as_result[W-1] != a_q[W-1]))
                       : ((a_q[W-1] != b_q[W-1]) && (as_result[W-1] != a_q[W-1]));
`endif
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      id_q         <= '0;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;
  assign as_add     = op_q;
  assign as_num1    = a_q;
  assign as_num2    = b_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed cases plus randomized traffic
// against a transaction-level round-robin/arithmetic reference model.
module tb_addsub_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_add;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_result;
`ifdef ADDSUB_ARB_OVF_EN
  logic             rsp_ovf;
`endif
  logic             busy;
  logic             as_add;
  logic [W-1:0]     as_num1;
  logic [W-1:0]     as_num2;
  logic [W-1:0]     as_result = '0;

  addsub_arbiter #(.N_REQ(N), .W(W), .ADDER_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_add(req_add),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .busy(busy), .as_add(as_add), .as_num1(as_num1), .as_num2(as_num2),
    .as_result(as_result)
  );

  always #5 clk = ~clk;

  // Shared add/sub unit with one cycle of latency.
  always @(posedge clk) as_result <= as_add ? as_num1 + as_num2 : as_num1 - as_num2;

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  bit [N-1:0]   pend;
  bit [N-1:0]   padd;
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  int           m_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_add[i]         = padd[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_res(input bit add, input logic [W-1:0] a, input logic [W-1:0] b);
    longint r;
    r = add ? longint'(a) + longint'(b) : longint'(a) - longint'(b);
    return r[W-1:0];
  endfunction

  function automatic bit ref_ovf(input bit add, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = add ? sa + sb : sa - sb;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // One transaction starting at an IDLE negedge; ends at the following IDLE negedge.
  task automatic txn(input int wait_n, input bit keep, output int got_id,
                     output logic [W-1:0] got_res, output logic got_ovf);
    int           w;
    logic [N-1:0] oh;
    logic [W-1:0] er;
    bit           eo;
    w = pick();
    if (w < 0) begin
      $display("FAIL txn: no pending request");
      $fatal(1);
    end
    oh = '0;
    oh[w] = 1'b1;
    er = ref_res(padd[w], pa[w], pb[w]);
    eo = ref_ovf(padd[w], pa[w], pb[w]);
    drive();
    rsp_ready = (wait_n == 0);
    #1;
    chk("grant", 64'(req_ready), 64'(oh));
    @(posedge clk);
    @(negedge clk);
    chk("as_add", 64'(as_add), 64'(padd[w]));
    chk("as_num1", 64'(as_num1), 64'(pa[w]));
    chk("as_num2", 64'(as_num2), 64'(pb[w]));
    m_ptr = w;
    if (!keep) pend[w] = 1'b0;
    drive();
    #1;
    chk("busy_t1", 64'(busy), 64'd1);
    chk("rv_t1", 64'(rsp_valid), 64'd0);
    chk("rdy_exec", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("rv_t2", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("rv_t3", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(w));
    chk("rsp_result", 64'(rsp_result), 64'(er));
`ifdef ADDSUB_ARB_OVF_EN
    chk("rsp_ovf", 64'(rsp_ovf), 64'(eo));
    got_ovf = rsp_ovf;
`else
    got_ovf = eo;
`endif
    got_id  = int'(rsp_id);
    got_res = rsp_result;
    for (int k = 1; k <= wait_n; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'(w));
      chk("bp_result", 64'(rsp_result), 64'(er));
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_num1", 64'(as_num1), 64'(pa[w]));
      if (k == wait_n) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rv_done", 64'(rsp_valid), 64'd0);
    chk("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           id;
    logic [W-1:0] res;
    logic         ovf;
    int           ord [5];
    ord = '{0, 1, 2, 0, 1};
    rsp_ready = 1'b1;
    pend = '1;
    padd = '1;
    for (int i = 0; i < N; i++) begin
      pa[i] = W'(i + 1);
      pb[i] = W'(10 * (i + 1));
    end
    drive();

    // Reset state with every requester asserting valid.
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_as", 64'({as_add, as_num1} | 33'(as_num2)), 64'd0);
`ifdef ADDSUB_ARB_OVF_EN
    chk("rst_ovf", 64'(rsp_ovf), 64'd0);
`endif
    rst_n = 1'b1;
    m_ptr = N - 1;

    // All three held valid: round-robin order 0,1,2,0,1.
    for (int i = 0; i < 5; i++) begin
      txn(0, 1'b1, id, res, ovf);
      chk("rr_order", 64'(id), 64'(ord[i]));
    end
    pend = '0;

    // Requester 1: 5 + 7.
    pend[1] = 1'b1; padd[1] = 1'b1; pa[1] = 32'd5; pb[1] = 32'd7;
    txn(0, 1'b0, id, res, ovf);
    chk("add_5_7", 64'(res), 64'd12);
    chk("add_id", 64'(id), 64'd1);

    // Requester 0: 3 - 5 with 4 cycles of backpressure.
    pend[0] = 1'b1; padd[0] = 1'b0; pa[0] = 32'd3; pb[0] = 32'd5;
    txn(4, 1'b0, id, res, ovf);
    chk("sub_3_5", 64'(res), 64'hFFFF_FFFE);
    chk("sub_ovf", 64'(ovf), 64'd0);

    // Overflow corners on requester 2.
    pend[2] = 1'b1; padd[2] = 1'b1; pa[2] = 32'h7FFF_FFFF; pb[2] = 32'd1;
    txn(0, 1'b0, id, res, ovf);
    chk("ovf_pos_res", 64'(res), 64'h8000_0000);
    chk("ovf_pos_flag", 64'(ovf), 64'd1);
    pend[2] = 1'b1; padd[2] = 1'b1; pa[2] = 32'hFFFF_FFFF; pb[2] = 32'd1;
    txn(0, 1'b0, id, res, ovf);
    chk("wrap_res", 64'(res), 64'd0);
    chk("wrap_flag", 64'(ovf), 64'd0);
    pend[2] = 1'b1; padd[2] = 1'b0; pa[2] = 32'h8000_0000; pb[2] = 32'd1;
    txn(0, 1'b0, id, res, ovf);
    chk("ovf_neg_res", 64'(res), 64'h7FFF_FFFF);
    chk("ovf_neg_flag", 64'(ovf), 64'd1);

    // Reset asserted during EXEC drops the operation.
    pend[1] = 1'b1; padd[1] = 1'b1; pa[1] = 32'h1234; pb[1] = 32'h1;
    drive();
    @(posedge clk);
    @(negedge clk);
    pend[1] = 1'b0;
    drive();
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy0", 64'(busy), 64'd0);
    chk("mid_valid0", 64'(rsp_valid), 64'd0);
    chk("mid_id0", 64'(rsp_id), 64'd0);
    chk("mid_result0", 64'(rsp_result), 64'd0);
    chk("mid_as0", 64'({as_add, as_num1} | 33'(as_num2)), 64'd0);
    pend[0] = 1'b1; padd[0] = 1'b1; pa[0] = 32'd100; pb[0] = 32'd23;
    pend[2] = 1'b1; padd[2] = 1'b0; pa[2] = 32'd50;  pb[2] = 32'd60;
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    m_ptr = N - 1;
    txn(0, 1'b0, id, res, ovf);
    chk("post_rst_first", 64'(id), 64'd0);
    txn(1, 1'b0, id, res, ovf);
    chk("post_rst_second", 64'(id), 64'd2);

    // Randomized traffic with legal withdrawals and corner operands.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            padd[i] = 1'($urandom_range(0, 1));
            pa[i]   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
            pb[i]   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
          end
        end else if ($urandom_range(0, 7) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (pend == '0) begin
        int j;
        j = int'($urandom_range(0, N - 1));
        pend[j] = 1'b1;
        padd[j] = 1'($urandom_range(0, 1));
        pa[j]   = $urandom();
        pb[j]   = $urandom();
      end
      txn(int'($urandom_range(0, 2)), 1'b0, id, res, ovf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit add/subtract datapath unit between up to N_REQ requesters (e.g. PC increment, branch-target calculation, ALU). It accepts one operation at a time over a valid/ready handshake, drives the operands into the shared unit, waits out the unit's fixed latency, and returns the registered result with the requester ID on one response channel. It sits between the requesting pipeline blocks and the add/sub unit.

## Interface
- N_REQ, 3: number of requesters, 2..8.
- W, 32: operand/result width.
- ADDER_LAT, 1: cycles from stable operands on as_* to a valid as_result; 0 means combinational.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant/accept; at most one bit high.
- req_add  in  N_REQ  per-requester op: 1 = add, 0 = subtract.
- req_a  in  N_REQ*W  packed first operands; requester i uses bits [i*W +: W].
- req_b  in  N_REQ*W  packed second operands, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(N_REQ)  requester index of the response.
- rsp_result  out  W  result.
- busy  out  1  high whenever the FSM is not in IDLE.
- as_add  out  1  op to the shared unit.
- as_num1, as_num2  out  W  operands to the shared unit.
- as_result  in  W  result from the shared unit.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE: if any req_valid bit is high, pick a winner by searching from index ptr+1 upward, wrapping modulo N_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle.
  - On that edge, latch req_add, req_a and req_b of the winner, plus its ID, into registers.
  - Set ptr = winner and go to EXEC.
  - req_ready is 0 in every other state.
- EXEC:
  - as_add, as_num1 and as_num2 come from the latched registers and stay constant for the whole of EXEC.
  - An internal counter holds EXEC for exactly ADDER_LAT+1 cycles.
  - On the last EXEC edge, capture as_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid = 1, and rsp_id, rsp_result and as_* are held stable.
  - On the edge where rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
  - No new grant happens in the same cycle as the response handshake.
- Requester protocol:
  - A requester must hold req_valid and its payload until it sees req_ready.
  - Dropping req_valid before the grant is legal; that requester is then simply not chosen.
- Arithmetic:
  - Add: result = (a + b) mod 2^W.
  - Subtract: result = (a − b) mod 2^W in two's complement.
  - The arbiter passes the unit's result through unmodified.
- rsp_ready is ignored while rsp_valid = 0.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - ptr = N_REQ−1, so requester 0 has first priority.
  - rsp_valid, rsp_id, rsp_result, as_add, as_num1, as_num2 and busy are all 0.
  - req_ready = 0 while rst_n = 0.
- Latency: a request handshake in cycle T gives rsp_valid = 1 in cycle T+ADDER_LAT+2.
- Throughput: one operation per ADDER_LAT+3 cycles when rsp_ready is held at 1.
- Backpressure: with rsp_ready = 0 the FSM stays in RESP indefinitely, all outputs are stable, and no grants are issued.
- Reset mid-operation: the in-flight op is dropped, no response is ever produced, and ptr returns to N_REQ−1.
- Single requester: it is granted every time it requests, regardless of ptr.

## Configuration
- ADDSUB_ARB_OVF_EN defined:
  - Adds the output port rsp_ovf (1 bit), registered together with rsp_result and reset to 0.
  - rsp_ovf is the signed overflow of the captured result.
  - For add: a[W−1] == b[W−1] and result[W−1] != a[W−1].
  - For subtract: a[W−1] != b[W−1] and result[W−1] != a[W−1].
- ADDSUB_ARB_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- All tests use N_REQ=3, W=32, ADDER_LAT=1 unless noted.
- Requester 1 adds 5 + 7, handshake at cycle T → rsp_valid at T+3 with rsp_result = 12, rsp_id = 1 and busy high from T+1.
- Requester 0 subtracts 3 − 5 → rsp_result = 0xFFFFFFFE; with the macro, rsp_ovf = 0.
- All three req_valid held high from reset, rsp_ready = 1 → grant order 0, 1, 2, 0, 1 with rsp_id matching, and exactly one req_ready bit high per IDLE cycle.
- rsp_ready held low for 4 cycles in RESP → rsp_valid, rsp_id and rsp_result stay constant, all req_ready bits stay 0, and the response is accepted on the 5th cycle.
- Overflow, with the macro defined:
  - 0x7FFFFFFF + 1 → 0x80000000, rsp_ovf = 1.
  - 0xFFFFFFFF + 1 → 0x00000000, rsp_ovf = 0.
  - 0x80000000 − 1 → 0x7FFFFFFF, rsp_ovf = 1.
- rst_n pulsed low during EXEC → all outputs go to 0 immediately and no response appears; after release, with requesters 0 and 2 valid, requester 0 is granted first.
